cpu_control_sequencer: RTL and testbench

Hardwired Moore control unit that sequences the single-bus 32-bit CPU datapath through fetch, decode and execute. Decodes IR[31:27] and drives every bus-out, register-enable, ALU-operation, memory and select-encode control line for one instruction at a time. Reads CON_FF back for conditional branches. Sits beside the datapath as its only source of control strobes.

---
 rtl/cpu_control_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_sequencer.sv
// Hardwired Moore control sequencer for the single-bus 32-bit CPU datapath (fetch/decode/execute).
// Optional macro INSTR_COUNT_EN enables the retired-instruction counter on instr_count.
module cpu_control_sequencer #(
   parameter int MEM_WAIT   = 1,
   parameter int DIV_CYCLES = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        stop,
   output logic        PCout,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        InPortout,
   output logic        MAR_enable,
   output logic        MDR_enable,
   output logic        IR_enable,
   output logic        Y_enable,
   output logic        PC_enable,
   output logic        Z_low_enable,
   output logic        Z_high_enable,
   output logic        HI_enable,
   output logic        LO_enable,
   output logic        OutPort_enable,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        CON_in,
   output logic        GRA,
   output logic        GRB,
   output logic        GRC,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [4:0]  operation,
   output logic        run,
   output logic        illegal,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
   } state_t;

   typedef struct packed {
      logic       pcOut;
      logic       zLowOut;
      logic       zHighOut;
      logic       mdrOut;
      logic       hiOut;
      logic       loOut;
      logic       cOut;
      logic       inPortOut;
      logic       marEn;
      logic       mdrEn;
      logic       irEn;
      logic       yEn;
      logic       pcEn;
      logic       zLowEn;
      logic       zHighEn;
      logic       hiEn;
      logic       loEn;
      logic       outPortEn;
      logic       incPc;
      logic       read;
      logic       write;
      logic       conIn;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       rIn;
      logic       rOut;
      logic       baOut;
      logic       run;
      logic       illegal;
      logic [4:0] operation;
   } ctl_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] MEM_LOAD = 5'(MEM_WAIT - 1);
   localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

   state_t      r_state;
   logic [4:0]  r_opcode;
   logic [4:0]  r_waitCnt;
   ctl_t        r_ctl;
   state_t      w_next;
   logic [4:0]  w_nextOp;
   logic        w_retire;
   logic        w_unusedIr;

   assign w_unusedIr = ^IR[26:0];

   function automatic logic isAlu3(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_SHL);
   endfunction

   function automatic logic isImm(input logic [4:0] op);
      return (op >= OP_ADDI) && (op <= OP_ORI);
   endfunction

   function automatic logic isMulDiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic isNegNot(input logic [4:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic isMem(input logic [4:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   endfunction

   // Final execute step of each instruction class; anything unlisted (single-step or undefined) ends in T3.
   function automatic state_t lastStep(input logic [4:0] op);
      if (isAlu3(op) || isImm(op) || op == OP_LDI) return S_T5;
      if (isNegNot(op))                             return S_T4;
      if (isMulDiv(op) || op == OP_BR)              return S_T6;
      if (op == OP_LD || op == OP_ST)               return S_T7;
      return S_T3;
   endfunction

   // Extra cycles a state is held for, loaded into the wait counter on entry.
   function automatic logic [4:0] holdLoad(input state_t s, input logic [4:0] op);
      if (s == S_T1)                    return MEM_LOAD;
      if (s == S_T4 && isMulDiv(op))    return DIV_LOAD;
      if (s == S_T6 && op == OP_LD)     return MEM_LOAD;
      return 5'd0;
   endfunction

   function automatic ctl_t decodeState(input state_t s, input logic [4:0] op, input logic con);
      ctl_t c;
      c = '0;
      c.run = (s != S_RST) && (s != S_PAUSE) && (s != S_HALT);
      case (s)
         S_T0: begin c.pcOut = 1'b1; c.marEn = 1'b1; c.incPc = 1'b1; end
         S_T1: begin c.read = 1'b1; c.mdrEn = 1'b1; end
         S_T2: begin c.mdrOut = 1'b1; c.irEn = 1'b1; end
         S_T3: begin
            if (isAlu3(op) || isImm(op)) begin
               c.grb = 1'b1; c.rOut = 1'b1; c.yEn = 1'b1;
            end else if (isNegNot(op)) begin
               c.grb = 1'b1; c.rOut = 1'b1; c.operation = op; c.zLowEn = 1'b1;
            end else if (isMulDiv(op)) begin
               c.gra = 1'b1; c.rOut = 1'b1; c.yEn = 1'b1;
            end else if (isMem(op)) begin
               c.grb = 1'b1; c.baOut = 1'b1; c.yEn = 1'b1;
            end else begin
               case (op)
                  OP_BR:   begin c.gra = 1'b1; c.rOut = 1'b1; c.conIn = 1'b1; end
                  OP_JR:   begin c.gra = 1'b1; c.rOut = 1'b1; c.pcEn = 1'b1; end
                  OP_IN:   begin c.inPortOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
                  OP_OUT:  begin c.gra = 1'b1; c.rOut = 1'b1; c.outPortEn = 1'b1; end
                  OP_MFHI: begin c.hiOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
                  OP_MFLO: begin c.loOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
                  default: c.illegal = 1'b1;
               endcase
            end
         end
         S_T4: begin
            if (isAlu3(op)) begin
               c.grc = 1'b1; c.rOut = 1'b1; c.operation = op; c.zLowEn = 1'b1;
            end else if (isImm(op)) begin
               c.cOut = 1'b1; c.operation = op; c.zLowEn = 1'b1;
            end else if (isNegNot(op)) begin
               c.zLowOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1;
            end else if (isMulDiv(op)) begin
               c.grb = 1'b1; c.rOut = 1'b1; c.operation = op; c.zLowEn = 1'b1; c.zHighEn = 1'b1;
            end else if (isMem(op)) begin
               c.cOut = 1'b1; c.operation = OP_ADD; c.zLowEn = 1'b1;
            end else if (op == OP_BR) begin
               c.pcOut = 1'b1; c.yEn = 1'b1;
            end
         end
         S_T5: begin
            if (isAlu3(op) || isImm(op) || op == OP_LDI) begin
               c.zLowOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1;
            end else if (isMulDiv(op)) begin
               c.zLowOut = 1'b1; c.loEn = 1'b1;
            end else if (op == OP_LD || op == OP_ST) begin
               c.zLowOut = 1'b1; c.marEn = 1'b1;
            end else if (op == OP_BR) begin
               c.cOut = 1'b1; c.operation = OP_ADD; c.zLowEn = 1'b1;
            end
         end
         S_T6: begin
            if (isMulDiv(op)) begin
               c.zHighOut = 1'b1; c.hiEn = 1'b1;
            end else if (op == OP_LD) begin
               c.read = 1'b1; c.mdrEn = 1'b1;
            end else if (op == OP_ST) begin
               c.gra = 1'b1; c.rOut = 1'b1; c.mdrEn = 1'b1;
            end else if (op == OP_BR) begin
               c.zLowOut = 1'b1; c.pcEn = con;
            end
         end
         S_T7: begin
            if (op == OP_LD) begin
               c.mdrOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1;
            end else if (op == OP_ST) begin
               c.write = 1'b1;
            end
         end
         default: c.run = 1'b0;
      endcase
      return c;
   endfunction

   // Next-state selection; the opcode is taken from IR on the T2 exit edge and held for execute.
   always_comb begin
      w_next   = r_state;
      w_nextOp = r_opcode;
      w_retire = 1'b0;
      case (r_state)
         S_RST, S_PAUSE: w_next = stop ? S_PAUSE : S_T0;
         S_T0:           w_next = S_T1;
         S_T1:           w_next = (r_waitCnt != 5'd0) ? S_T1 : S_T2;
         S_T2: begin
            w_nextOp = IR[31:27];
            if (IR[31:27] == OP_NOP) begin
               w_retire = 1'b1;
               w_next   = stop ? S_PAUSE : S_T0;
            end else if (IR[31:27] == OP_HALT) begin
               w_next = S_HALT;
            end else begin
               w_next = S_T3;
            end
         end
         S_HALT:         w_next = S_HALT;
         default: begin
            if (r_waitCnt != 5'd0) begin
               w_next = r_state;
            end else if (r_state == lastStep(r_opcode)) begin
               w_retire = 1'b1;
               w_next   = stop ? S_PAUSE : S_T0;
            end else begin
               w_next = state_t'(r_state + 4'd1);
            end
         end
      endcase
   end

   // State, hold counter and registered control word; clear aborts whatever is in flight.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state   <= S_RST;
         r_opcode  <= 5'd0;
         r_waitCnt <= 5'd0;
         r_ctl     <= '0;
      end else begin
         r_state  <= w_next;
         r_opcode <= w_nextOp;
         if (w_next != r_state)
            r_waitCnt <= holdLoad(w_next, w_nextOp);
         else if (r_waitCnt != 5'd0)
            r_waitCnt <= r_waitCnt - 5'd1;
         r_ctl <= decodeState(w_next, w_nextOp, CON_FF);
      end
   end

   assign PCout          = r_ctl.pcOut;
   assign ZLowout        = r_ctl.zLowOut;
   assign ZHighout       = r_ctl.zHighOut;
   assign MDRout         = r_ctl.mdrOut;
   assign HIout          = r_ctl.hiOut;
   assign LOout          = r_ctl.loOut;
   assign Cout           = r_ctl.cOut;
   assign InPortout      = r_ctl.inPortOut;
   assign MAR_enable     = r_ctl.marEn;
   assign MDR_enable     = r_ctl.mdrEn;
   assign IR_enable      = r_ctl.irEn;
   assign Y_enable       = r_ctl.yEn;
   assign PC_enable      = r_ctl.pcEn;
   assign Z_low_enable   = r_ctl.zLowEn;
   assign Z_high_enable  = r_ctl.zHighEn;
   assign HI_enable      = r_ctl.hiEn;
   assign LO_enable      = r_ctl.loEn;
   assign OutPort_enable = r_ctl.outPortEn;
   assign IncPC          = r_ctl.incPc;
   assign Read           = r_ctl.read;
   assign Write          = r_ctl.write;
   assign CON_in         = r_ctl.conIn;
   assign GRA            = r_ctl.gra;
   assign GRB            = r_ctl.grb;
   assign GRC            = r_ctl.grc;
   assign Rin            = r_ctl.rIn;
   assign Rout           = r_ctl.rOut;
   assign BAout          = r_ctl.baOut;
   assign operation      = r_ctl.operation;
   assign run            = r_ctl.run;
   assign illegal        = r_ctl.illegal;

`ifdef INSTR_COUNT_EN
   logic [31:0] r_instrCount;

   // Counts instructions that complete their execute phase; halt never completes one.
   always_ff @(posedge clock) begin
      if (clear)
         r_instrCount <= 32'd0;
      else if (w_retire)
         r_instrCount <= r_instrCount + 32'd1;
   end

   assign instr_count = r_instrCount;
`else
   logic w_unusedRetire;

   assign w_unusedRetire = w_retire;
   assign instr_count    = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed self-checking bench for cpu_control_sequencer (MEM_WAIT=3, DIV_CYCLES=4).
module tb_cpu_control_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        CON_FF;
   logic        stop;
   logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
   logic MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable, Z_low_enable, Z_high_enable;
   logic HI_enable, LO_enable, OutPort_enable, IncPC, Read, Write, CON_in;
   logic GRA, GRB, GRC, Rin, Rout, BAout, run, illegal;
   logic [4:0]  operation;
   logic [31:0] instr_count;

   typedef logic [34:0] vec_t;

   localparam vec_t B_PCOUT   = vec_t'(1) << 34;
   localparam vec_t B_ZLOWOUT = vec_t'(1) << 33;
   localparam vec_t B_ZHIOUT  = vec_t'(1) << 32;
   localparam vec_t B_MDROUT  = vec_t'(1) << 31;
   localparam vec_t B_HIOUT   = vec_t'(1) << 30;
   localparam vec_t B_LOOUT   = vec_t'(1) << 29;
   localparam vec_t B_COUT    = vec_t'(1) << 28;
   localparam vec_t B_INPOUT  = vec_t'(1) << 27;
   localparam vec_t B_MAREN   = vec_t'(1) << 26;
   localparam vec_t B_MDREN   = vec_t'(1) << 25;
   localparam vec_t B_IREN    = vec_t'(1) << 24;
   localparam vec_t B_YEN     = vec_t'(1) << 23;
   localparam vec_t B_PCEN    = vec_t'(1) << 22;
   localparam vec_t B_ZLEN    = vec_t'(1) << 21;
   localparam vec_t B_ZHEN    = vec_t'(1) << 20;
   localparam vec_t B_HIEN    = vec_t'(1) << 19;
   localparam vec_t B_LOEN    = vec_t'(1) << 18;
   localparam vec_t B_OPEN    = vec_t'(1) << 17;
   localparam vec_t B_INCPC   = vec_t'(1) << 16;
   localparam vec_t B_READ    = vec_t'(1) << 15;
   localparam vec_t B_WRITE   = vec_t'(1) << 14;
   localparam vec_t B_CONIN   = vec_t'(1) << 13;
   localparam vec_t B_GRA     = vec_t'(1) << 12;
   localparam vec_t B_GRB     = vec_t'(1) << 11;
   localparam vec_t B_GRC     = vec_t'(1) << 10;
   localparam vec_t B_RIN     = vec_t'(1) << 9;
   localparam vec_t B_ROUT    = vec_t'(1) << 8;
   localparam vec_t B_BAOUT   = vec_t'(1) << 7;
   localparam vec_t B_RUN     = vec_t'(1) << 6;
   localparam vec_t B_ILL     = vec_t'(1) << 5;

   localparam vec_t F0 = B_PCOUT | B_MAREN | B_INCPC | B_RUN;
   localparam vec_t F1 = B_READ | B_MDREN | B_RUN;
   localparam vec_t F2 = B_MDROUT | B_IREN | B_RUN;

   vec_t  obs;
   vec_t  expSeq[$];
   int    passCount = 0;
   int    totalCount = 0;
   int    expCount = 0;
   string tag;

   assign obs = {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
                 MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable, Z_low_enable,
                 Z_high_enable, HI_enable, LO_enable, OutPort_enable, IncPC, Read, Write,
                 CON_in, GRA, GRB, GRC, Rin, Rout, BAout, run, illegal, operation};

   cpu_control_sequencer #(.MEM_WAIT(3), .DIV_CYCLES(4)) dut (
      .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .stop(stop),
      .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
      .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
      .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
      .Y_enable(Y_enable), .PC_enable(PC_enable), .Z_low_enable(Z_low_enable),
      .Z_high_enable(Z_high_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
      .OutPort_enable(OutPort_enable), .IncPC(IncPC), .Read(Read), .Write(Write),
      .CON_in(CON_in), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .operation(operation), .run(run), .illegal(illegal),
      .instr_count(instr_count)
   );

   // Free-running clock; the bench drives and samples on the falling edge.
   always #5 clock = ~clock;

   // Fetch phase with MEM_WAIT=3: T0, three T1 cycles, T2.
   task automatic loadFetch();
      expSeq.delete();
      expSeq.push_back(F0);
      expSeq.push_back(F1);
      expSeq.push_back(F1);
      expSeq.push_back(F1);
      expSeq.push_back(F2);
   endtask

   task automatic test_reset();
      clear = 1'b1; stop = 1'b0; CON_FF = 1'b0; IR = 32'h0;
      @(negedge clock);
      @(negedge clock);
      totalCount++;
      if (obs !== vec_t'(0)) $display("[TB] FAIL reset_outputs got %h want %h", obs, vec_t'(0));
      else passCount++;
      totalCount++;
      if (instr_count !== 32'd0) $display("[TB] FAIL reset_count got %h want 0", instr_count);
      else passCount++;
      clear = 1'b0;
      @(negedge clock);
      totalCount++;
      if (obs !== F0) $display("[TB] FAIL reset_first_T0 got %h want %h", obs, F0);
      else passCount++;
   endtask

   task automatic test_alu();
      logic [31:0] irs[3] = '{32'h1A920000, 32'h60000000, 32'h88000000};
      for (int k = 0; k < 3; k++) begin
         IR = irs[k];
         loadFetch();
         case (k)
            0: begin
               tag = "add";
               expSeq.push_back(B_GRB | B_ROUT | B_YEN | B_RUN);
               expSeq.push_back(B_GRC | B_ROUT | B_ZLEN | B_RUN | vec_t'(5'b00011));
               expSeq.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
            end
            1: begin
               tag = "addi";
               expSeq.push_back(B_GRB | B_ROUT | B_YEN | B_RUN);
               expSeq.push_back(B_COUT | B_ZLEN | B_RUN | vec_t'(5'b01100));
               expSeq.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
            end
            default: begin
               tag = "neg";
               expSeq.push_back(B_GRB | B_ROUT | B_ZLEN | B_RUN | vec_t'(5'b10001));
               expSeq.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
            end
         endcase
         expSeq.push_back(F0);
         for (int i = 0; i < expSeq.size(); i++) begin
            totalCount++;
            if (obs !== expSeq[i]) $display("[TB] FAIL %s cycle %0d got %h want %h", tag, i, obs, expSeq[i]);
            else passCount++;
            if (i < expSeq.size() - 1) @(negedge clock);
         end
         expCount++;
      end
   endtask

   task automatic test_load();
      logic [31:0] irs[2] = '{32'h00800054, 32'h08000000};
      for (int k = 0; k < 2; k++) begin
         IR = irs[k];
         tag = (k == 0) ? "ld" : "ldi";
         loadFetch();
         expSeq.push_back(B_GRB | B_BAOUT | B_YEN | B_RUN);
         expSeq.push_back(B_COUT | B_ZLEN | B_RUN | vec_t'(5'b00011));
         if (k == 0) begin
            expSeq.push_back(B_ZLOWOUT | B_MAREN | B_RUN);
            expSeq.push_back(F1);
            expSeq.push_back(F1);
            expSeq.push_back(F1);
            expSeq.push_back(B_MDROUT | B_GRA | B_RIN | B_RUN);
         end else begin
            expSeq.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
         end
         expSeq.push_back(F0);
         for (int i = 0; i < expSeq.size(); i++) begin
            totalCount++;
            if (obs !== expSeq[i]) $display("[TB] FAIL %s cycle %0d got %h want %h", tag, i, obs, expSeq[i]);
            else passCount++;
            if (i < expSeq.size() - 1) @(negedge clock);
         end
         expCount++;
      end
   endtask

   task automatic test_store_abort();
      logic sawWrite;
      IR = 32'h10000000;
      for (int k = 0; k < 2; k++) begin
         tag = (k == 0) ? "st" : "st_abort";
         loadFetch();
         expSeq.push_back(B_GRB | B_BAOUT | B_YEN | B_RUN);
         expSeq.push_back(B_COUT | B_ZLEN | B_RUN | vec_t'(5'b00011));
         expSeq.push_back(B_ZLOWOUT | B_MAREN | B_RUN);
         expSeq.push_back(B_GRA | B_ROUT | B_MDREN | B_RUN);
         if (k == 0) begin
            expSeq.push_back(B_WRITE | B_RUN);
            expSeq.push_back(F0);
         end
         for (int i = 0; i < expSeq.size(); i++) begin
            totalCount++;
            if (obs !== expSeq[i]) $display("[TB] FAIL %s cycle %0d got %h want %h", tag, i, obs, expSeq[i]);
            else passCount++;
            if (i < expSeq.size() - 1) @(negedge clock);
         end
         if (k == 0) expCount++;
      end
      sawWrite = 1'b0;
      clear = 1'b1;
      @(negedge clock);
      sawWrite |= Write;
      totalCount++;
      if (obs !== vec_t'(0)) $display("[TB] FAIL st_abort_rst got %h want %h", obs, vec_t'(0));
      else passCount++;
      clear = 1'b0;
      expCount = 0;
      @(negedge clock);
      sawWrite |= Write;
      totalCount++;
      if (obs !== F0) $display("[TB] FAIL st_abort_T0 got %h want %h", obs, F0);
      else passCount++;
      totalCount++;
      if (sawWrite !== 1'b0) $display("[TB] FAIL st_abort_write got %b want 0", sawWrite);
      else passCount++;
   endtask

   task automatic test_branch();
      IR = 32'h98000000;
      for (int k = 0; k < 2; k++) begin
         CON_FF = (k == 1);
         tag = (k == 0) ? "br_not_taken" : "br_taken";
         loadFetch();
         expSeq.push_back(B_GRA | B_ROUT | B_CONIN | B_RUN);
         expSeq.push_back(B_PCOUT | B_YEN | B_RUN);
         expSeq.push_back(B_COUT | B_ZLEN | B_RUN | vec_t'(5'b00011));
         expSeq.push_back(B_ZLOWOUT | B_RUN | ((k == 1) ? B_PCEN : vec_t'(0)));
         expSeq.push_back(F0);
         for (int i = 0; i < expSeq.size(); i++) begin
            totalCount++;
            if (obs !== expSeq[i]) $display("[TB] FAIL %s cycle %0d got %h want %h", tag, i, obs, expSeq[i]);
            else passCount++;
            if (i < expSeq.size() - 1) @(negedge clock);
         end
         expCount++;
      end
      CON_FF = 1'b0;
   endtask

   task automatic test_muldiv();
      vec_t mulStep;
      for (int k = 0; k < 2; k++) begin
         IR = (k == 0) ? 32'h78000000 : 32'h80000000;
         tag = (k == 0) ? "mul" : "div";
         mulStep = B_GRB | B_ROUT | B_ZLEN | B_ZHEN | B_RUN | ((k == 0) ? vec_t'(5'b01111) : vec_t'(5'b10000));
         loadFetch();
         expSeq.push_back(B_GRA | B_ROUT | B_YEN | B_RUN);
         for (int j = 0; j < 4; j++) expSeq.push_back(mulStep);
         expSeq.push_back(B_ZLOWOUT | B_LOEN | B_RUN);
         expSeq.push_back(B_ZHIOUT | B_HIEN | B_RUN);
         expSeq.push_back(F0);
         for (int i = 0; i < expSeq.size(); i++) begin
            totalCount++;
            if (obs !== expSeq[i]) $display("[TB] FAIL %s cycle %0d got %h want %h", tag, i, obs, expSeq[i]);
            else passCount++;
            if (i < expSeq.size() - 1) @(negedge clock);
         end
         expCount++;
      end
   endtask

   task automatic test_single_step();
      logic [31:0] irs[7] = '{32'hA0000000, 32'hB0000000, 32'hB8000000, 32'hC0000000,
                              32'hC8000000, 32'hF8000000, 32'hD0000000};
      vec_t steps[6] = '{B_GRA | B_ROUT | B_PCEN | B_RUN,
                         B_INPOUT | B_GRA | B_RIN | B_RUN,
                         B_GRA | B_ROUT | B_OPEN | B_RUN,
                         B_HIOUT | B_GRA | B_RIN | B_RUN,
                         B_LOOUT | B_GRA | B_RIN | B_RUN,
                         B_ILL | B_RUN};
      for (int k = 0; k < 7; k++) begin
         IR = irs[k];
         tag = $sformatf("single_op%0d", k);
         loadFetch();
         if (k < 6) expSeq.push_back(steps[k]);
         expSeq.push_back(F0);
         for (int i = 0; i < expSeq.size(); i++) begin
            totalCount++;
            if (obs !== expSeq[i]) $display("[TB] FAIL %s cycle %0d got %h want %h", tag, i, obs, expSeq[i]);
            else passCount++;
            if (i < expSeq.size() - 1) @(negedge clock);
         end
         expCount++;
      end
   endtask

   task automatic test_count();
      logic [31:0] want;
`ifdef INSTR_COUNT_EN
      want = 32'(expCount);
`else
      want = 32'd0;
`endif
      totalCount++;
      if (instr_count !== want) $display("[TB] FAIL instr_count got %0d want %0d", instr_count, want);
      else passCount++;
   endtask

   task automatic test_pause_halt();
      IR = 32'hA0000000;
      stop = 1'b1;
      loadFetch();
      expSeq.push_back(B_GRA | B_ROUT | B_PCEN | B_RUN);
      for (int j = 0; j < 5; j++) expSeq.push_back(vec_t'(0));
      for (int i = 0; i < expSeq.size(); i++) begin
         totalCount++;
         if (obs !== expSeq[i]) $display("[TB] FAIL pause cycle %0d got %h want %h", i, obs, expSeq[i]);
         else passCount++;
         if (i == expSeq.size() - 1) stop = 1'b0;
         @(negedge clock);
      end
      expCount++;
      totalCount++;
      if (obs !== F0) $display("[TB] FAIL pause_resume got %h want %h", obs, F0);
      else passCount++;
      test_count();
      IR = 32'hD8000000;
      loadFetch();
      for (int j = 0; j < 6; j++) expSeq.push_back(vec_t'(0));
      for (int i = 0; i < expSeq.size(); i++) begin
         if (i == 6) IR = 32'h1A920000;
         totalCount++;
         if (obs !== expSeq[i]) $display("[TB] FAIL halt cycle %0d got %h want %h", i, obs, expSeq[i]);
         else passCount++;
         @(negedge clock);
      end
      test_count();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      expCount = 0;
      @(negedge clock);
      totalCount++;
      if (obs !== F0) $display("[TB] FAIL halt_clear_T0 got %h want %h", obs, F0);
      else passCount++;
      test_count();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_count();
      test_store_abort();
      test_branch();
      test_muldiv();
      test_single_step();
      test_count();
      test_pause_halt();
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

   // Watchdog so a stuck run still terminates with a visible failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout got running want finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
